// File: rtl/seq_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module : seq_frame_loader_pkg
//  Brief  : Host-protocol constants, sequencer register map and loader FSM
//           state encoding shared by the frame loader.
//  Rev    : 1.0  initial release
// ============================================================================
package seq_frame_loader_pkg;

    // Host protocol bytes
    localparam logic [7:0]  SEQ_FRAME_SOF        = 8'hA5;
    localparam logic [7:0]  SEQ_FRAME_ACK        = 8'h06;
    localparam logic [7:0]  SEQ_FRAME_NAK        = 8'h15;

    // Sequence generator register map
    localparam logic [15:0] SEQ_BASE_ADDR        = 16'h1000;
    localparam logic [15:0] SEQ_CHANNEL_STRIDE   = 16'h0100;
    localparam logic [15:0] SEQ_GLOBAL_CTRL_ADDR = 16'h0F00;
    localparam logic [15:0] SEQ_CTRL_OFS         = 16'h0000;
    localparam logic [15:0] SEQ_CONFIG_OFS       = 16'h0004;
    localparam logic [15:0] SEQ_DIVISOR_OFS      = 16'h0008;
    localparam logic [15:0] SEQ_DATA0_OFS        = 16'h0010;

    // Loader FSM states; every state that accepts bytes encodes below WRITE
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_FLAGS = 3'd1;
    localparam logic [2:0]  ST_LEN   = 3'd2;
    localparam logic [2:0]  ST_DIV   = 3'd3;
    localparam logic [2:0]  ST_DATA  = 3'd4;
    localparam logic [2:0]  ST_CHK   = 3'd5;
    localparam logic [2:0]  ST_WRITE = 3'd6;
    localparam logic [2:0]  ST_RESP  = 3'd7;

    // Number of DATA bytes carried for a sequence of len bits
    function automatic logic [5:0] data_bytes(input logic [7:0] len);
        logic [8:0] w_sum;
        w_sum = {1'b0, len} + 9'd7;
        return w_sum[8:3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module : seq_frame_loader
//  Brief  : Receives framed sequence-load commands from the CDC RX byte path,
//           checks them, replays them as a cfg-bus write burst and answers
//           with a single ACK/NAK byte on the CDC TX byte path.
//  Rev    : 1.0  initial release
// ============================================================================
module seq_frame_loader
    import seq_frame_loader_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int MAX_SEQ_LEN    = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] cfg_addr,
    output logic [31:0] cfg_wdata,
    output logic        cfg_write,
    output logic        busy,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err
);

    localparam int             NW      = MAX_SEQ_LEN / 32;
    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    // Burst step numbers after the CTRL disarm (step 0) and the data words
    localparam logic [3:0]     S_DIV   = 4'(NW + 1);
    localparam logic [3:0]     S_CFG   = 4'(NW + 2);
    localparam logic [3:0]     S_ARM   = 4'(NW + 3);
    localparam logic [3:0]     S_GO    = 4'(NW + 4);

    logic [2:0]             state_q,  state_d;
    logic [MAX_SEQ_LEN-1:0] buf_q,    buf_d;
    logic [7:0]             xor_q,    xor_d;
    logic [4:0]             cnt_q,    cnt_d;
    logic [3:0]             ch_q,     ch_d;
    logic                   loop_q,   loop_d;
    logic                   go_q,     go_d;
    logic [7:0]             len_q,    len_d;
    logic [31:0]            div_q,    div_d;
    logic                   err_q,    err_d;
    logic [TW-1:0]          to_q,     to_d;
    logic [3:0]             step_q,   step_d;
    logic [7:0]             resp_q,   resp_d;
    logic [15:0]            ok_q,     ok_d;
    logic [15:0]            bad_q,    bad_d;

    logic                   rx_fire;
    logic [5:0]             nb;
    logic [3:0]             w_idx;
    logic [15:0]            ch_base;

    assign rx_ready   = !rst && (state_q < ST_WRITE);
    assign rx_fire    = rx_valid && rx_ready;
    assign tx_valid   = (state_q == ST_RESP);
    assign tx_data    = resp_q;
    assign busy       = (state_q != ST_IDLE);
    assign frames_ok  = ok_q;
    assign frames_err = bad_q;
    assign nb         = data_bytes(len_q);
    assign w_idx      = step_q - 4'd1;
    assign ch_base    = SEQ_BASE_ADDR + 16'(ch_q) * SEQ_CHANNEL_STRIDE;

    // Write-burst decoder: one register write per WRITE cycle, selected by step
    always_comb begin
        cfg_write = 1'b0;
        cfg_addr  = 16'h0000;
        cfg_wdata = 32'h0000_0000;
        if (state_q == ST_WRITE) begin
            cfg_write = 1'b1;
            if (step_q == 4'd0) begin
                cfg_addr  = ch_base + SEQ_CTRL_OFS;
            end else if (step_q <= 4'(NW)) begin
                cfg_addr  = ch_base + SEQ_DATA0_OFS + {10'd0, w_idx, 2'b00};
                cfg_wdata = buf_q[w_idx*32 +: 32];
            end else if (step_q == S_DIV) begin
                cfg_addr  = ch_base + SEQ_DIVISOR_OFS;
                cfg_wdata = div_q;
            end else if (step_q == S_CFG) begin
                cfg_addr  = ch_base + SEQ_CONFIG_OFS;
                cfg_wdata = {7'd0, loop_q, 16'd0, len_q};
            end else if (step_q == S_ARM) begin
                cfg_addr  = ch_base + SEQ_CTRL_OFS;
                cfg_wdata = 32'd1;
            end else begin
                cfg_addr  = SEQ_GLOBAL_CTRL_ADDR;
                cfg_wdata = 32'd1;
            end
        end
    end

    // Frame parser, validation, burst sequencing, response and timeout
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        xor_d   = xor_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        loop_d  = loop_q;
        go_d    = go_q;
        len_d   = len_q;
        div_d   = div_q;
        err_d   = err_q;
        to_d    = to_q;
        step_d  = step_q;
        resp_d  = resp_q;
        ok_d    = ok_q;
        bad_d   = bad_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_fire && rx_data == SEQ_FRAME_SOF) begin
                    state_d = ST_FLAGS;
                    buf_d   = '0;
                    xor_d   = 8'h00;
                    err_d   = 1'b0;
                    cnt_d   = 5'd0;
                    to_d    = '0;
                end
            end
            ST_WRITE: begin
                step_d = step_q + 4'd1;
                if ((step_q == S_ARM && !go_q) || step_q == S_GO) begin
                    state_d = ST_RESP;
                    resp_d  = SEQ_FRAME_ACK;
                    step_d  = 4'd0;
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    if (resp_q == SEQ_FRAME_ACK) begin
                        if (ok_q != 16'hFFFF) ok_d = ok_q + 16'd1;
                    end else begin
                        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                    resp_d  = 8'h00;
                end
            end
            default: begin
                if (rx_fire) begin
                    to_d = '0;
                    case (state_q)
                        ST_FLAGS: begin
                            xor_d  = xor_q ^ rx_data;
                            ch_d   = rx_data[3:0];
                            loop_d = rx_data[4];
                            go_d   = rx_data[5];
                            if (rx_data[7:6] != 2'b00 ||
                                int'({28'd0, rx_data[3:0]}) >= NUM_CHANNELS)
                                err_d = 1'b1;
                            state_d = ST_LEN;
                        end
                        ST_LEN: begin
                            xor_d   = xor_q ^ rx_data;
                            len_d   = rx_data;
                            if (rx_data == 8'h00) err_d = 1'b1;
                            cnt_d   = 5'd0;
                            state_d = ST_DIV;
                        end
                        ST_DIV: begin
                            xor_d = xor_q ^ rx_data;
                            div_d[cnt_q[1:0]*8 +: 8] = rx_data;
                            if (cnt_q == 5'd3) begin
                                cnt_d   = 5'd0;
                                state_d = (len_q == 8'h00) ? ST_CHK : ST_DATA;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        ST_DATA: begin
                            xor_d = xor_q ^ rx_data;
                            buf_d[cnt_q*8 +: 8] = rx_data;
                            if ({1'b0, cnt_q} == nb - 6'd1) begin
                                cnt_d   = 5'd0;
                                state_d = ST_CHK;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        default: begin
                            if (rx_data == xor_q && !err_q) begin
                                state_d = ST_WRITE;
                                step_d  = 4'd0;
                            end else begin
                                state_d = ST_RESP;
                                resp_d  = SEQ_FRAME_NAK;
                            end
                        end
                    endcase
                end else if (to_q == TO_LAST) begin
                    state_d = ST_RESP;
                    resp_d  = SEQ_FRAME_NAK;
                    buf_d   = '0;
                    to_d    = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
        endcase
    end

    // State register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            xor_q   <= 8'h00;
            cnt_q   <= 5'd0;
            ch_q    <= 4'd0;
            loop_q  <= 1'b0;
            go_q    <= 1'b0;
            len_q   <= 8'h00;
            div_q   <= 32'd0;
            err_q   <= 1'b0;
            to_q    <= '0;
            step_q  <= 4'd0;
            resp_q  <= 8'h00;
            ok_q    <= 16'd0;
            bad_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            xor_q   <= xor_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            loop_q  <= loop_d;
            go_q    <= go_d;
            len_q   <= len_d;
            div_q   <= div_d;
            err_q   <= err_d;
            to_q    <= to_d;
            step_q  <= step_d;
            resp_q  <= resp_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
        end
    end

endmodule
`default_nettype wire
